// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit, one radix-2 step per cycle.
module ex_muldiv #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [RAW-1:0]  waddr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [XLEN-1:0] result_o,
  output logic            done_o,
  output logic            reg_we_o,
  output logic [RAW-1:0]  reg_waddr_o
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      f3_q;
  logic [RAW-1:0]  waddr_q;
  logic [XLEN-1:0] m_q;
  logic [2*XLEN-1:0] acc_q, step_d, prod;
  logic            neg_q, sgn1, s1, s2, div_zero, div_ovf, ge;
  logic [XLEN-1:0] a1, a2, quo, rem, res;
  logic [XLEN:0]   sum, top, diff;
  // acc_q holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    sgn1     = ~(funct3_i[0] & (funct3_i[1] | funct3_i[2]));
    s1       = op1_i[XLEN-1] & sgn1;
    s2       = op2_i[XLEN-1] & sgn1 & (funct3_i != 3'b010);
    a1       = s1 ? -op1_i : op1_i;
    a2       = s2 ? -op2_i : op2_i;
    div_zero = funct3_i[2] & (op2_i == '0);
    div_ovf  = funct3_i[2] & ~funct3_i[0] & (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&op2_i);
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
    top      = acc_q[2*XLEN-1:XLEN-1];
    ge       = top >= {1'b0, m_q};
    diff     = top - {1'b0, m_q};
    step_d   = f3_q[2] ? {(ge ? diff[XLEN-1:0] : top[XLEN-1:0]), acc_q[XLEN-2:0], ge}
                       : {sum, acc_q[XLEN-1:1]};
    prod     = neg_q ? -acc_q : acc_q;
    quo      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem      = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    res      = ~f3_q[2] ? ((f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                        : (f3_q[1] ? rem : quo);
  end
  assign done_o      = state_q == DONE;
  assign reg_we_o    = done_o;
  assign result_o    = done_o ? res : '0;
  assign reg_waddr_o = done_o ? waddr_q : '0;
  assign stall_o     = (state_q == IDLE & start_i & ~flush_i) | (state_q == CALC);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      waddr_q <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (state_q == IDLE) begin
      if (start_i) begin
        f3_q    <= funct3_i;
        waddr_q <= waddr_i;
        cnt_q   <= '0;
        if (div_zero) begin
          acc_q   <= {op1_i, {XLEN{1'b1}}};
          neg_q   <= 1'b0;
          state_q <= DONE;
        end else if (div_ovf) begin
          acc_q   <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
          neg_q   <= 1'b0;
          state_q <= DONE;
        end else begin
          m_q     <= funct3_i[2] ? a2 : a1;
          acc_q   <= {{XLEN{1'b0}}, (funct3_i[2] ? a1 : a2)};
          neg_q   <= (funct3_i[2] & funct3_i[1]) ? s1 : (s1 ^ s2);
          state_q <= CALC;
        end
      end
    end else if (state_q == CALC) begin
      acc_q <= step_d;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(XLEN-1)) state_q <= DONE;
    end else begin
      state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv with a plain-arithmetic reference model.
module tb_ex_muldiv;
  logic        clk = 0, rst = 1, start_i = 0, flush_i = 0;
  logic [2:0]  funct3_i = 0;
  logic [31:0] op1_i = 0, op2_i = 0, result_o;
  logic [4:0]  waddr_i = 0, reg_waddr_o;
  logic        stall_o, done_o, reg_we_o;
  int checks = 0, errors = 0;
  typedef struct packed {logic [31:0] r; logic [4:0] w;} exp_t;
  exp_t sbq[$];

  ex_muldiv #(.XLEN(32), .RAW(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .funct3_i(funct3_i), .op1_i(op1_i),
    .op2_i(op2_i), .waddr_i(waddr_i), .flush_i(flush_i), .stall_o(stall_o),
    .result_o(result_o), .done_o(done_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int q;
    logic ovf;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (ovf) return 32'h80000000;
        q = $signed(a) / $signed(b); return q;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        q = $signed(a) % $signed(b); return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever a result is presented
  always @(negedge clk) begin
    exp_t e;
    if (done_o) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done result %h waddr %0d at %0t", result_o, reg_waddr_o, $time);
      end else begin
        e = sbq.pop_front();
        chk("result", 64'(result_o), 64'(e.r));
        chk("waddr", 64'(reg_waddr_o), 64'(e.w));
        chk("we", 64'(reg_we_o), 64'd1);
      end
    end else if (!rst) begin
      chk("idle_outputs", 64'({result_o, reg_waddr_o, reg_we_o}), 64'd0);
    end
  end

  task automatic wait_done(input string name, output int lat, output int stalls);
    lat = 0; stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); lat++;
      if (done_o) break;
      if (stall_o) stalls++;
    end
    if (!done_o) chk({name, "_timeout"}, 64'(done_o), 64'd1);
  endtask

  // Called just after a negedge with the DUT idle; returns one cycle after the result
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] w, input logic [31:0] exp_r);
    int lat, stalls;
    bit special;
    special = f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    sbq.push_back('{r: exp_r, w: w});
    funct3_i = f; op1_i = a; op2_i = b; waddr_i = w; start_i = 1;
    #1 chk("stall_on_start", 64'(stall_o), 64'd1);
    @(posedge clk); #1 start_i = 0;
    wait_done("op", lat, stalls);
    chk("latency", 64'(lat), special ? 64'd1 : 64'd33);
    chk("stall_cycles", 64'(stalls), special ? 64'd0 : 64'd32);
    @(negedge clk);
  endtask

  task automatic abort_run(input bit use_rst);
    funct3_i = 3'd0; op1_i = 32'd123; op2_i = 32'd456; waddr_i = 5'd9; start_i = 1;
    @(posedge clk); #1 start_i = 0;
    repeat (11) @(negedge clk);
    if (use_rst) rst = 1; else flush_i = 1;
    @(posedge clk); #1 rst = 0; flush_i = 0;
    chk(use_rst ? "rst_stall" : "flush_stall", 64'(stall_o), 64'd0);
    chk(use_rst ? "rst_outputs" : "flush_outputs", 64'({result_o, reg_waddr_o, reg_we_o, done_o}), 64'd0);
    repeat (40) @(negedge clk);
  endtask

  initial begin
    logic [2:0] f;
    logic [31:0] a, b;
    int lat, stalls;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({stall_o, result_o, done_o, reg_we_o, reg_waddr_o}), 64'd0);
    rst = 0;
    @(negedge clk);
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000000);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFF);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE);
    issue(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD);
    issue(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF);
    issue(3'd5, 32'd100, 32'd7, 5'd7, 32'd14);
    issue(3'd7, 32'd100, 32'd7, 5'd8, 32'd2);
    issue(3'd4, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF);
    issue(3'd6, 32'd5, 32'd0, 5'd11, 32'd5);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h0);
    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom_range(7));
      a = $urandom; b = $urandom;
      if ($urandom_range(5) == 0) b = 0;
      if ($urandom_range(7) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if ($urandom_range(3) == 0) b = b >> $urandom_range(31);
      issue(f, a, b, 5'($urandom), model(f, a, b));
    end
    abort_run(0);
    abort_run(1);
    // start during CALC must be ignored; the original operation completes
    sbq.push_back('{r: model(3'd4, 32'd1000, 32'hFFFFFFF6), w: 5'd20});
    funct3_i = 3'd4; op1_i = 32'd1000; op2_i = 32'hFFFFFFF6; waddr_i = 5'd20; start_i = 1;
    @(posedge clk); #1 start_i = 0;
    repeat (5) @(negedge clk);
    funct3_i = 3'd0; op1_i = 32'd3; op2_i = 32'd3; waddr_i = 5'd21; start_i = 1;
    @(posedge clk); #1 start_i = 0;
    wait_done("ignored_start", lat, stalls);
    @(negedge clk);
    issue(3'd3, 32'h12345678, 32'h9ABCDEF0, 5'd22, model(3'd3, 32'h12345678, 32'h9ABCDEF0));
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
